// File: rtl/s_core_pkg.sv
// ---------------------------------------------------------------------------
// s_core_pkg
// Shared definitions for the s_core program loader: host command codes,
// payload lengths, loader FSM state encoding and sticky error-bit positions.
// ---------------------------------------------------------------------------
package s_core_pkg;

   // Host command codes (first byte of every packet)
   localparam logic [7:0] CMD_WRITE_IMEM = 8'h01;
   localparam logic [7:0] CMD_WRITE_REG  = 8'h02;
   localparam logic [7:0] CMD_SET_START  = 8'h03;
   localparam logic [7:0] CMD_RUN        = 8'h04;
   localparam logic [7:0] CMD_HALT       = 8'h05;
   localparam logic [7:0] CMD_CLR_ERR    = 8'h06;

   // Payload byte counts following the command byte
   localparam logic [3:0] LEN_WRITE_IMEM = 4'd8;
   localparam logic [3:0] LEN_WRITE_REG  = 4'd5;
   localparam logic [3:0] LEN_SET_START  = 4'd4;
   localparam logic [3:0] LEN_NONE       = 4'd0;

   // Loader FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   // Bit positions inside the sticky error vector
   localparam int ERR_UNKNOWN_CMD = 0;
   localparam int ERR_MISALIGNED  = 1;
   localparam int ERR_TIMEOUT     = 2;
   localparam int ERR_RUNNING     = 3;

   function automatic logic cmd_known(input logic [7:0] cmd);
      return (cmd >= CMD_WRITE_IMEM) && (cmd <= CMD_CLR_ERR);
   endfunction

   function automatic logic [3:0] cmd_len(input logic [7:0] cmd);
      logic [3:0] len;
      case (cmd)
         CMD_WRITE_IMEM: len = LEN_WRITE_IMEM;
         CMD_WRITE_REG:  len = LEN_WRITE_REG;
         CMD_SET_START:  len = LEN_SET_START;
         default:        len = LEN_NONE;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/s_core_loader_timer.sv
// ---------------------------------------------------------------------------
// s_core_loader_timer
// Idle-cycle counter used to abort stalled packets. Counts every enabled
// cycle in which clr is low; expired pulses during the TIMEOUT_CYCLES-th
// consecutive such cycle, so the owner can drop the packet at that edge.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   en       counting enabled (loader is collecting payload)
//   clr      restart the count (byte accepted / not collecting payload)
//   expired  one-cycle pulse on the TIMEOUT_CYCLES-th idle cycle
// ---------------------------------------------------------------------------
module s_core_loader_timer #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst || clr || !en) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // count_reg holds the number of idle cycles already completed, so the
   // current cycle is the TIMEOUT_CYCLES-th one when it equals N-1.
   assign expired = en && !clr && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/s_core_loader.sv
// ---------------------------------------------------------------------------
// s_core_loader
// Byte-stream program loader for s_core. Decodes host command packets,
// assembles little-endian payload words and drives the core setup
// interface (instruction-memory writes, register preloads, start PC and
// setup/run control).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_rx_valid, i_rx_data    host byte stream
//   o_rx_ready               byte accepted when valid & ready (low in COMMIT)
//   o_setup                  1 = core held in setup, 0 = running
//   o_inst_mem_we/addr/data  one-cycle IMEM write strobe with address/word
//   o_load_reg_we/addr/data  one-cycle register-file write strobe
//   o_pc_instr_start_addr    core start PC
//   o_err_flags              sticky: [0] unknown cmd, [1] misaligned,
//                            [2] timeout, [3] write while running
//   o_wr_count               successful IMEM + register writes (wraps)
// ---------------------------------------------------------------------------
module s_core_loader
   import s_core_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_data,
   output logic              o_rx_ready,
   output logic              o_setup,
   output logic              o_inst_mem_we,
   output logic [ADDR_W-1:0] o_inst_mem_addr,
   output logic [DATA_W-1:0] o_inst_mem_data,
   output logic              o_load_reg_we,
   output logic [4:0]        o_load_reg_addr,
   output logic [DATA_W-1:0] o_load_reg_data,
   output logic [ADDR_W-1:0] o_pc_instr_start_addr,
   output logic [3:0]        o_err_flags,
   output logic [CNT_W-1:0]  o_wr_count
);

   state_t            state_reg, state_next;
   logic [7:0]        cmd_reg;
   logic [3:0]        cnt_reg;
   // Holds the most recent 7 payload bytes; together with the incoming byte
   // this forms the full 8-byte WRITE_IMEM payload. Shorter payloads end up
   // left-justified, so the final 32-bit word always sits at the top.
   logic [55:0]       asm_reg;
   logic [63:0]       asm_shift;

   logic              setup_reg;
   logic [ADDR_W-1:0] imem_addr_reg;
   logic [DATA_W-1:0] imem_data_reg;
   logic [4:0]        reg_addr_reg;
   logic [DATA_W-1:0] reg_data_reg;
   logic [ADDR_W-1:0] start_reg;
   logic [3:0]        err_reg;
   logic [CNT_W-1:0]  wr_count_reg;

   logic              byte_acc;
   logic              last_byte;
   logic              timer_clr;
   logic              timer_expired;
   logic [31:0]       start_cand;
   logic              start_ok;

   assign byte_acc   = i_rx_valid && o_rx_ready;
   assign asm_shift  = {i_rx_data, asm_reg};
   assign last_byte  = (state_reg == ST_PAYLOAD) && byte_acc &&
                       (cnt_reg == cmd_len(cmd_reg) - 4'd1);
   assign timer_clr  = byte_acc || (state_reg != ST_PAYLOAD);
   // SET_START payload is exactly one word, so during COMMIT it is the top
   // 32 bits of the assembly register.
   assign start_cand = asm_reg[55:24];

   s_core_loader_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .en      (state_reg == ST_PAYLOAD),
      .clr     (timer_clr),
      .expired (timer_expired)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (byte_acc && cmd_known(i_rx_data)) begin
               state_next = (cmd_len(i_rx_data) == LEN_NONE) ? ST_COMMIT : ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (last_byte) begin
               state_next = ST_COMMIT;
            end else if (timer_expired) begin
               state_next = ST_IDLE;
            end
         end
         ST_COMMIT: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Strobes are decoded from the COMMIT state so they appear in the cycle
   // right after the last payload byte, with addr/data already latched.
   always_comb begin
      o_rx_ready    = (state_reg != ST_COMMIT);
      o_inst_mem_we = 1'b0;
      o_load_reg_we = 1'b0;
      start_ok      = 1'b0;
      if (state_reg == ST_COMMIT) begin
         o_inst_mem_we = (cmd_reg == CMD_WRITE_IMEM) && setup_reg &&
                         (imem_addr_reg[1:0] == 2'b00);
         o_load_reg_we = (cmd_reg == CMD_WRITE_REG) && setup_reg &&
                         (reg_addr_reg != 5'd0);
         start_ok      = (cmd_reg == CMD_SET_START) && setup_reg &&
                         (start_cand[1:0] == 2'b00);
      end
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_reg       <= '0;
         cnt_reg       <= '0;
         asm_reg       <= '0;
         setup_reg     <= 1'b1;
         imem_addr_reg <= '0;
         imem_data_reg <= '0;
         reg_addr_reg  <= '0;
         reg_data_reg  <= '0;
         start_reg     <= '0;
         err_reg       <= '0;
         wr_count_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (byte_acc) begin
                  if (cmd_known(i_rx_data)) begin
                     cmd_reg <= i_rx_data;
                     cnt_reg <= '0;
                  end else begin
                     err_reg[ERR_UNKNOWN_CMD] <= 1'b1;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (byte_acc) begin
                  asm_reg <= asm_shift[63:8];
                  cnt_reg <= cnt_reg + 4'd1;
                  // Latch outputs on the final byte so they are stable for
                  // the whole COMMIT cycle and hold until the next commit.
                  if (last_byte && cmd_reg == CMD_WRITE_IMEM) begin
                     imem_addr_reg <= ADDR_W'(asm_shift[31:0]);
                     imem_data_reg <= asm_shift[63:32];
                  end
                  if (last_byte && cmd_reg == CMD_WRITE_REG) begin
                     reg_addr_reg <= asm_shift[28:24];
                     reg_data_reg <= asm_shift[63:32];
                  end
               end else if (timer_expired) begin
                  err_reg[ERR_TIMEOUT] <= 1'b1;
               end
            end
            ST_COMMIT: begin
               case (cmd_reg)
                  CMD_WRITE_IMEM: begin
                     if (imem_addr_reg[1:0] != 2'b00) err_reg[ERR_MISALIGNED] <= 1'b1;
                     if (!setup_reg)                  err_reg[ERR_RUNNING]    <= 1'b1;
                     if (o_inst_mem_we)               wr_count_reg <= wr_count_reg + 1'b1;
                  end
                  CMD_WRITE_REG: begin
                     if (!setup_reg)    err_reg[ERR_RUNNING] <= 1'b1;
                     if (o_load_reg_we) wr_count_reg <= wr_count_reg + 1'b1;
                  end
                  CMD_SET_START: begin
                     if (start_cand[1:0] != 2'b00) err_reg[ERR_MISALIGNED] <= 1'b1;
                     if (!setup_reg)               err_reg[ERR_RUNNING]    <= 1'b1;
                     if (start_ok)                 start_reg <= ADDR_W'(start_cand);
                  end
                  CMD_RUN:     setup_reg <= 1'b0;
                  CMD_HALT:    setup_reg <= 1'b1;
                  CMD_CLR_ERR: err_reg   <= '0;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign o_setup               = setup_reg;
   assign o_inst_mem_addr       = imem_addr_reg;
   assign o_inst_mem_data       = imem_data_reg;
   assign o_load_reg_addr       = reg_addr_reg;
   assign o_load_reg_data       = reg_data_reg;
   assign o_pc_instr_start_addr = start_reg;
   assign o_err_flags           = err_reg;
   assign o_wr_count            = wr_count_reg;

endmodule

// File: tb/tb_s_core_loader.sv
// ---------------------------------------------------------------------------
// tb_s_core_loader
// Directed packets with hand-computed expectations. Expected write strobes
// are queued by the stimulus; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_s_core_loader;

   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        o_rx_ready;
   logic        o_setup;
   logic        o_inst_mem_we;
   logic [31:0] o_inst_mem_addr;
   logic [31:0] o_inst_mem_data;
   logic        o_load_reg_we;
   logic [4:0]  o_load_reg_addr;
   logic [31:0] o_load_reg_data;
   logic [31:0] o_pc_instr_start_addr;
   logic [3:0]  o_err_flags;
   logic [15:0] o_wr_count;

   s_core_loader #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (16)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .i_rx_valid            (rx_valid),
      .i_rx_data             (rx_data),
      .o_rx_ready            (o_rx_ready),
      .o_setup               (o_setup),
      .o_inst_mem_we         (o_inst_mem_we),
      .o_inst_mem_addr       (o_inst_mem_addr),
      .o_inst_mem_data       (o_inst_mem_data),
      .o_load_reg_we         (o_load_reg_we),
      .o_load_reg_addr       (o_load_reg_addr),
      .o_load_reg_data       (o_load_reg_data),
      .o_pc_instr_start_addr (o_pc_instr_start_addr),
      .o_err_flags           (o_err_flags),
      .o_wr_count            (o_wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t imem_q[$];
   exp_t reg_q[$];

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   int acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   // ---------------- Monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (o_inst_mem_we) begin
            n_vec++;
            if (imem_q.size() == 0) begin
               n_miss++;
               $display("FAIL imem_strobe: unexpected write addr=%h data=%h cyc=%0d",
                        o_inst_mem_addr, o_inst_mem_data, cyc);
            end else begin
               exp_t e;
               e = imem_q.pop_front();
               if (o_inst_mem_addr !== e.addr || o_inst_mem_data !== e.data || cyc != e.cyc) begin
                  n_miss++;
                  $display("FAIL imem_write: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                           o_inst_mem_addr, o_inst_mem_data, cyc, e.addr, e.data, e.cyc);
               end else begin
                  $display("ok   imem_write addr=%h data=%h cyc=%0d", e.addr, e.data, cyc);
               end
            end
         end
         if (o_load_reg_we) begin
            n_vec++;
            if (reg_q.size() == 0) begin
               n_miss++;
               $display("FAIL reg_strobe: unexpected write idx=%0d data=%h cyc=%0d",
                        o_load_reg_addr, o_load_reg_data, cyc);
            end else begin
               exp_t e;
               e = reg_q.pop_front();
               if (32'(o_load_reg_addr) !== e.addr || o_load_reg_data !== e.data || cyc != e.cyc) begin
                  n_miss++;
                  $display("FAIL reg_write: got idx=%0d data=%h cyc=%0d, expected idx=%0d data=%h cyc=%0d",
                           o_load_reg_addr, o_load_reg_data, cyc, e.addr, e.data, e.cyc);
               end else begin
                  $display("ok   reg_write idx=%0d data=%h cyc=%0d", e.addr, e.data, cyc);
               end
            end
         end
      end
   end

   // ---------------- Stimulus helpers ----------------
   // Presents one byte; returns at the negedge before the accepting posedge.
   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!o_rx_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!o_rx_ready) begin
         n_vec++;
         n_miss++;
         $display("FAIL rx_ready_wait: ready stuck low for byte %h", b);
      end
      acc_cyc = cyc;
   endtask

   // Bytes are listed in wire order, first byte in the most significant slot.
   task automatic send_pkt(input int n, input logic [71:0] bytes);
      for (int i = 0; i < n; i++) begin
         send_byte(bytes[8*(n-1-i) +: 8]);
      end
   endtask

   task automatic release_bus();
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic exp_imem(input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a; e.data = d; e.cyc = acc_cyc + 1;
      imem_q.push_back(e);
   endtask

   task automatic exp_reg(input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = a; e.data = d; e.cyc = acc_cyc + 1;
      reg_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_setup"},    32'(o_setup), 32'd1);
      chk({tag, "_rdy"},      32'(o_rx_ready), 32'd1);
      chk({tag, "_imem_adr"}, o_inst_mem_addr, 32'h0);
      chk({tag, "_imem_dat"}, o_inst_mem_data, 32'h0);
      chk({tag, "_reg_adr"},  32'(o_load_reg_addr), 32'h0);
      chk({tag, "_start"},    o_pc_instr_start_addr, 32'h0);
      chk({tag, "_err"},      32'(o_err_flags), 32'h0);
      chk({tag, "_cnt"},      32'(o_wr_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- Directed sequence ----------------
   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      do_reset();
      chk_reset_state("reset");

      // IMEM write addr 4, data 0x00127413
      send_pkt(9, 72'h01_04_00_00_00_13_74_12_00);
      exp_imem(32'h4, 32'h00127413);
      release_bus();
      idle(2);
      chk("imem1_cnt", 32'(o_wr_count), 32'd1);
      chk("imem1_setup", 32'(o_setup), 32'd1);

      // Register x6 = 4, then x0 write dropped silently
      send_pkt(6, 72'h02_06_04_00_00_00);
      exp_reg(32'd6, 32'h4);
      release_bus();
      idle(2);
      send_pkt(6, 72'h02_00_FF_FF_FF_FF);
      release_bus();
      idle(2);
      chk("reg_cnt", 32'(o_wr_count), 32'd2);
      chk("reg_err", 32'(o_err_flags), 32'h0);

      // Start PC, RUN, write while running, HALT
      send_pkt(5, 72'h03_04_00_00_00);
      release_bus();
      idle(2);
      chk("start_pc", o_pc_instr_start_addr, 32'h4);
      chk("pre_run_setup", 32'(o_setup), 32'd1);
      send_pkt(1, 72'h04);
      release_bus();
      idle(2);
      chk("run_setup", 32'(o_setup), 32'd0);
      send_pkt(9, 72'h01_08_00_00_00_78_56_34_12);
      release_bus();
      idle(2);
      chk("run_wr_err", 32'(o_err_flags), 32'h8);
      chk("run_wr_cnt", 32'(o_wr_count), 32'd2);
      send_pkt(1, 72'h05);
      release_bus();
      idle(2);
      chk("halt_setup", 32'(o_setup), 32'd1);

      // Misaligned, unknown command, clear
      send_pkt(1, 72'h06);
      release_bus();
      idle(2);
      chk("clr1_err", 32'(o_err_flags), 32'h0);
      send_pkt(9, 72'h01_02_00_00_00_DD_CC_BB_AA);
      release_bus();
      idle(2);
      chk("misalign_err", 32'(o_err_flags), 32'h2);
      send_pkt(1, 72'h07);
      release_bus();
      idle(2);
      chk("unknown_err", 32'(o_err_flags), 32'h3);
      send_pkt(1, 72'h06);
      release_bus();
      idle(2);
      chk("clr2_err", 32'(o_err_flags), 32'h0);
      chk("clr2_cnt", 32'(o_wr_count), 32'd2);

      // Timeout: err must appear after exactly TMO idle cycles
      send_pkt(3, 72'h01_10_00);
      release_bus();
      idle(TMO - 1);
      chk("tmo_early_err", 32'(o_err_flags), 32'h0);
      idle(1);
      chk("tmo_err", 32'(o_err_flags), 32'h4);
      chk("tmo_rdy", 32'(o_rx_ready), 32'd1);
      send_pkt(9, 72'h01_10_00_00_00_EF_BE_AD_DE);
      exp_imem(32'h10, 32'hDEADBEEF);
      release_bus();
      idle(2);
      chk("tmo_after_cnt", 32'(o_wr_count), 32'd3);

      // Reset in the middle of a WRITE_IMEM payload
      send_pkt(4, 72'h01_20_00_00);
      release_bus();
      do_reset();
      idle(2);
      chk_reset_state("midrst");

      // Back-to-back packets with valid held high throughout
      send_pkt(6, 72'h02_25_78_56_34_12);
      exp_reg(32'd5, 32'h12345678);
      send_pkt(9, 72'h01_08_00_00_00_44_33_22_11);
      exp_imem(32'h8, 32'h11223344);
      send_pkt(6, 72'h02_1F_01_00_00_00);
      exp_reg(32'd31, 32'h1);
      release_bus();
      idle(3);
      chk("b2b_cnt", 32'(o_wr_count), 32'd3);
      chk("b2b_err", 32'(o_err_flags), 32'h0);

      idle(4);
      chk("imem_q_empty", 32'(imem_q.size()), 32'd0);
      chk("reg_q_empty", 32'(reg_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
